// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle for inst_queue.
// master drives fetch slots and decoder control; slave is the queue itself.
interface inst_queue_if;
  logic        rdy;
  logic        mistaken;
  logic        inEnO;
  logic [31:0] inPCO;
  logic [31:0] inInstO;
  logic        inEnT;
  logic [31:0] inPCT;
  logic [31:0] inInstT;
  logic        ifStall;
  logic        decStall;
  logic        outEnO;
  logic [31:0] outPCO;
  logic [31:0] outInstO;
  logic        outEnT;
  logic [31:0] outPCT;
  logic [31:0] outInstT;

  modport master (
    output rdy, mistaken, inEnO, inPCO, inInstO, inEnT, inPCT, inInstT, decStall,
    input  ifStall, outEnO, outPCO, outInstO, outEnT, outPCT, outInstT
  );

  modport slave (
    input  rdy, mistaken, inEnO, inPCO, inInstO, inEnT, inPCT, inInstT, decStall,
    output ifStall, outEnO, outPCO, outInstO, outEnT, outPCT, outInstT
  );
endinterface

// File: rtl/inst_queue.sv
// Two-wide in-order instruction queue between fetch and decode.
// Circular buffer of {PC, inst}; up to two pushes and two pops per cycle, flushable.
module inst_queue #(
  parameter int unsigned DEPTH = 8
) (
  input logic         clk,
  input logic         rst,
  inst_queue_if.slave q
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  logic [31:0] pc_mem_q   [DEPTH];
  logic [31:0] inst_mem_q [DEPTH];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  ptr_t head_nxt, tail_nxt;
  logic if_stall, out_en_o, out_en_t;
  logic push_en, push_two;
  cnt_t push_n, pop_n;

  always_comb begin
    head_nxt = head_q + ptr_t'(1);
    tail_nxt = tail_q + ptr_t'(1);

    // Stall on occupancy alone so fetch never has to reason about same-cycle pops.
    if_stall = count_q > cnt_t'(DEPTH - 2);

    out_en_o = (count_q != '0) & ~q.mistaken & q.rdy;
    out_en_t = (count_q >= cnt_t'(2)) & ~q.mistaken & q.rdy;

    push_en  = rst & q.rdy & ~q.mistaken & ~if_stall & q.inEnO;
    push_two = push_en & q.inEnT;
    push_n   = cnt_t'(push_en) + cnt_t'(push_two);
    pop_n    = q.decStall ? '0 : (cnt_t'(out_en_o) + cnt_t'(out_en_t));

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (q.rdy) begin
      if (q.mistaken) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        head_d  = head_q + ptr_t'(pop_n);
        tail_d  = tail_q + ptr_t'(push_n);
        count_d = count_q + push_n - pop_n;
      end
    end
  end

  always_comb begin
    q.ifStall  = if_stall;
    q.outEnO   = out_en_o;
    q.outEnT   = out_en_t;
    q.outPCO   = out_en_o ? pc_mem_q[head_q]     : '0;
    q.outInstO = out_en_o ? inst_mem_q[head_q]   : '0;
    q.outPCT   = out_en_t ? pc_mem_q[head_nxt]   : '0;
    q.outInstT = out_en_t ? inst_mem_q[head_nxt] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; validity comes only from count_q.
  always_ff @(posedge clk) begin
    if (push_en) begin
      pc_mem_q[tail_q]   <= q.inPCO;
      inst_mem_q[tail_q] <= q.inInstO;
    end
    if (push_two) begin
      pc_mem_q[tail_nxt]   <= q.inPCT;
      inst_mem_q[tail_nxt] <= q.inInstT;
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_inst_queue;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_queue_if qif ();

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a plain queue of {pc, inst} entries, oldest first.
  logic [63:0] mq[$];

  typedef struct {
    bit          rst, rdy, mis, dec, eno;
    logic [31:0] pco, insto;
    bit          ent;
    logic [31:0] pct, instt;
    bit          x_eo, x_et;
    logic [31:0] x_pco, x_insto, x_pct, x_instt;
    bit          x_stall;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit rd, input bit mis, input bit dec, input bit eno,
                       input logic [31:0] pco, input logic [31:0] io, input bit ent,
                       input logic [31:0] pct, input logic [31:0] it);
    rst          = r;
    qif.rdy      = rd;
    qif.mistaken = mis;
    qif.decStall = dec;
    qif.inEnO    = eno;
    qif.inPCO    = pco;
    qif.inInstO  = io;
    qif.inEnT    = ent;
    qif.inPCT    = pct;
    qif.inInstT  = it;
  endtask

  // Applies the queue rules to the model at a rising edge, from pre-edge occupancy.
  task automatic model_update();
    int  sz;
    int  npop;
    bit  full;
    sz   = mq.size();
    full = sz > int'(DEPTH) - 2;
    if (!rst) mq.delete();
    else if (!qif.rdy) begin
    end else if (qif.mistaken) mq.delete();
    else begin
      npop = qif.decStall ? 0 : (sz >= 2 ? 2 : sz);
      repeat (npop) void'(mq.pop_front());
      if (qif.inEnO && !full) begin
        mq.push_back({qif.inPCO, qif.inInstO});
        if (qif.inEnT) mq.push_back({qif.inPCT, qif.inInstT});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_model();
    int          nv;
    logic [63:0] e0, e1;
    nv = (qif.rdy && !qif.mistaken) ? (mq.size() >= 2 ? 2 : mq.size()) : 0;
    e0 = (nv >= 1) ? mq[0] : 64'h0;
    e1 = (nv >= 2) ? mq[1] : 64'h0;
    chk("rnd_outEnO", 32'(qif.outEnO), 32'(nv >= 1));
    chk("rnd_outEnT", 32'(qif.outEnT), 32'(nv >= 2));
    chk("rnd_outPCO", qif.outPCO, e0[63:32]);
    chk("rnd_outInstO", qif.outInstO, e0[31:0]);
    chk("rnd_outPCT", qif.outPCT, e1[63:32]);
    chk("rnd_outInstT", qif.outInstT, e1[31:0]);
    chk("rnd_ifStall", 32'(qif.ifStall), 32'(mq.size() > int'(DEPTH) - 2));
  endtask

  logic [31:0] got[$];

  initial begin
    // rst rdy mis dec eno pco insto ent pct instt | eo et pco insto pct instt stall
    tbl[0]  = '{0,1,0,1,0, 0,0, 0, 0,0,  0,0, 0,0, 0,0, 0};
    tbl[1]  = '{1,1,0,1,1, 32'h0,32'h13, 1, 32'h4,32'h100093,  0,0, 0,0, 0,0, 0};
    tbl[2]  = '{1,1,0,1,0, 0,0, 0, 0,0,  1,1, 32'h0,32'h13, 32'h4,32'h100093, 0};
    tbl[3]  = '{1,1,0,1,1, 32'h8,32'h10000008, 1, 32'hC,32'h1000000C,
                1,1, 32'h0,32'h13, 32'h4,32'h100093, 0};
    tbl[4]  = '{1,1,0,1,1, 32'h10,32'h10000010, 1, 32'h14,32'h10000014,
                1,1, 32'h0,32'h13, 32'h4,32'h100093, 0};
    tbl[5]  = '{1,1,0,1,1, 32'h18,32'h10000018, 1, 32'h1C,32'h1000001C,
                1,1, 32'h0,32'h13, 32'h4,32'h100093, 0};
    tbl[6]  = '{1,1,0,1,1, 32'h20,32'h10000020, 1, 32'h24,32'h10000024,
                1,1, 32'h0,32'h13, 32'h4,32'h100093, 1};
    tbl[7]  = '{1,1,0,0,0, 0,0, 0, 0,0,  1,1, 32'h0,32'h13, 32'h4,32'h100093, 1};
    tbl[8]  = '{1,1,0,0,0, 0,0, 0, 0,0,
                1,1, 32'h8,32'h10000008, 32'hC,32'h1000000C, 0};
    tbl[9]  = '{1,1,1,0,1, 32'h40,32'h10000040, 1, 32'h44,32'h10000044,  0,0, 0,0, 0,0, 0};
    tbl[10] = '{1,1,0,1,1, 32'h50,32'h10000050, 0, 0,0,  0,0, 0,0, 0,0, 0};
    tbl[11] = '{1,0,0,1,1, 32'h60,32'h10000060, 0, 0,0,  0,0, 0,0, 0,0, 0};
    tbl[12] = '{1,1,0,1,0, 0,0, 0, 0,0,  1,0, 32'h50,32'h10000050, 0,0, 0};
    tbl[13] = '{0,1,0,0,0, 0,0, 0, 0,0,  1,0, 32'h50,32'h10000050, 0,0, 0};
    tbl[14] = '{1,1,0,1,0, 0,0, 0, 0,0,  0,0, 0,0, 0,0, 0};
    tbl[15] = '{1,1,0,1,0, 0,0, 1, 32'h70,32'h10000070,  0,0, 0,0, 0,0, 0};
    tbl[16] = '{1,1,0,1,0, 0,0, 0, 0,0,  0,0, 0,0, 0,0, 0};

    drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].mis, tbl[i].dec, tbl[i].eno, tbl[i].pco,
            tbl[i].insto, tbl[i].ent, tbl[i].pct, tbl[i].instt);
      #2;
      chk($sformatf("vec%0d_outEnO", i), 32'(qif.outEnO), 32'(tbl[i].x_eo));
      chk($sformatf("vec%0d_outEnT", i), 32'(qif.outEnT), 32'(tbl[i].x_et));
      chk($sformatf("vec%0d_outPCO", i), qif.outPCO, tbl[i].x_pco);
      chk($sformatf("vec%0d_outInstO", i), qif.outInstO, tbl[i].x_insto);
      chk($sformatf("vec%0d_outPCT", i), qif.outPCT, tbl[i].x_pct);
      chk($sformatf("vec%0d_outInstT", i), qif.outInstT, tbl[i].x_instt);
      chk($sformatf("vec%0d_ifStall", i), 32'(qif.ifStall), 32'(tbl[i].x_stall));
      tick();
    end

    // Nine single pushes drained one per cycle, wrapping the pointers.
    for (int c = 0; c < 12; c++) begin
      drive(1, 1, 0, 0, c < 9, 32'(4 * c), 32'h10000000 + 32'(4 * c), 0, 0, 0);
      #2;
      if (qif.outEnO) got.push_back(qif.outPCO);
      chk("wrap_outEnT", 32'(qif.outEnT), 32'h0);
      tick();
    end
    chk("wrap_count", 32'(got.size()), 32'd9);
    foreach (got[i]) chk($sformatf("wrap_pc%0d", i), got[i], 32'(4 * i));

    // Three entries, then rdy low with push and pop requested.
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 0, 1, 1, 32'h100 + 32'(4 * c), 32'h20000000 + 32'(c), 0, 0, 0);
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 0, 0, 1, 32'h200, 32'h200, 1, 32'h204, 32'h204);
      #2;
      chk("rdy0_outEnO", 32'(qif.outEnO), 32'h0);
      chk("rdy0_outEnT", 32'(qif.outEnT), 32'h0);
      chk("rdy0_outPCO", qif.outPCO, 32'h0);
      tick();
    end
    drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rdy1_outPCO", qif.outPCO, 32'h100);
    chk("rdy1_outPCT", qif.outPCT, 32'h104);
    chk("rdy1_outInstT", qif.outInstT, 32'h20000001);
    tick();
    drive(0, 1, 0, 0, 1, 32'h300, 32'h300, 0, 0, 0);
    tick();
    drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_outEnO", 32'(qif.outEnO), 32'h0);
    chk("rst_outPCO", qif.outPCO, 32'h0);
    chk("rst_outInstO", qif.outInstO, 32'h0);
    chk("rst_outPCT", qif.outPCT, 32'h0);
    chk("rst_ifStall", 32'(qif.ifStall), 32'h0);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(99) >= 2, $urandom_range(99) < 90, $urandom_range(99) < 4,
            $urandom_range(99) < 45, $urandom_range(99) < 60, $urandom, $urandom,
            $urandom_range(99) < 50, $urandom, $urandom);
      #2;
      check_model();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
